// File: rtl/wb_bridge_decoder_if.sv
// Bus bundle between the Nios Wishbone bridge port, wb_bridge_decoder and its two Wishbone slaves.
// The master modport is the decoder's view. The slave modport is the bridge/slave environment's view.
interface wb_bridge_decoder_if #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 32
);
   logic              br_en;
   logic              br_rw;
   logic [ADDR_W-1:0] br_addr;
   logic [3:0]        br_sel;
   logic [DATA_W-1:0] br_wdata;
   logic              sel_mem;
   logic [DATA_W-1:0] br_rdata;
   logic              br_ack;
   logic              err_o;

   logic [31:0]       mem_adr_o;
   logic [3:0]        mem_sel_o;
   logic              mem_we_o;
   logic              mem_cyc_o;
   logic              mem_stb_o;
   logic [DATA_W-1:0] mem_dat_o;
   logic [DATA_W-1:0] mem_dat_i;
   logic              mem_ack_i;
   logic              mem_err_i;

   logic [9:0]        ctrl_adr_o;
   logic [3:0]        ctrl_sel_o;
   logic              ctrl_we_o;
   logic              ctrl_cyc_o;
   logic              ctrl_stb_o;
   logic [DATA_W-1:0] ctrl_dat_o;
   logic [DATA_W-1:0] ctrl_dat_i;
   logic              ctrl_ack_i;
   logic              ctrl_err_i;

   modport master (
      input  br_en, br_rw, br_addr, br_sel, br_wdata, sel_mem,
      output br_rdata, br_ack, err_o,
      output mem_adr_o, mem_sel_o, mem_we_o, mem_cyc_o, mem_stb_o, mem_dat_o,
      input  mem_dat_i, mem_ack_i, mem_err_i,
      output ctrl_adr_o, ctrl_sel_o, ctrl_we_o, ctrl_cyc_o, ctrl_stb_o, ctrl_dat_o,
      input  ctrl_dat_i, ctrl_ack_i, ctrl_err_i
   );

   modport slave (
      output br_en, br_rw, br_addr, br_sel, br_wdata, sel_mem,
      input  br_rdata, br_ack, err_o,
      input  mem_adr_o, mem_sel_o, mem_we_o, mem_cyc_o, mem_stb_o, mem_dat_o,
      output mem_dat_i, mem_ack_i, mem_err_i,
      input  ctrl_adr_o, ctrl_sel_o, ctrl_we_o, ctrl_cyc_o, ctrl_stb_o, ctrl_dat_o,
      output ctrl_dat_i, ctrl_ack_i, ctrl_err_i
   );
endinterface

// File: rtl/wb_bridge_decoder.sv
// Registered transaction engine steering bridge requests to the ethmac control slave or the shared memory.
// Optional macro BUS_TIMEOUT_EN turns a hung slave into an error termination after TIMEOUT_CYC cycles.
module wb_bridge_decoder #(
   parameter int                ADDR_W      = 15,
   parameter int                DATA_W      = 32,
   parameter int                TIMEOUT_CYC = 255,
   parameter logic [DATA_W-1:0] ERR_DATA    = 32'hDEAD_BEEF
) (
   input logic                  wb_clk_i,
   input logic                  reset_n,
   wb_bridge_decoder_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACTIVE  = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t            state_r,    state_s;
   logic              tgt_mem_r,  tgt_mem_s;
   logic [ADDR_W-1:0] adr_r,      adr_s;
   logic [3:0]        sel_r,      sel_s;
   logic [DATA_W-1:0] wdat_r,     wdat_s;
   logic              mem_cyc_r,  mem_cyc_s;
   logic              ctrl_cyc_r, ctrl_cyc_s;
   logic              mem_we_r,   mem_we_s;
   logic              ctrl_we_r,  ctrl_we_s;
   logic [DATA_W-1:0] rdata_r,    rdata_s;
   logic              ack_r,      ack_s;
   logic              err_r,      err_s;

   logic              slv_ack_s;
   logic              slv_err_s;
   logic [DATA_W-1:0] slv_dat_s;
   logic              tmo_s;
   logic              fail_s;

`ifdef BUS_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
   logic [CNT_W-1:0]  cnt_r, cnt_s;

   // Timeout fires on the edge where the no-response count would reach TIMEOUT_CYC
   always_comb begin
      tmo_s = (cnt_r == CNT_W'(TIMEOUT_CYC - 1));
   end
`else
   // Without the timeout feature ACTIVE waits for the slave indefinitely
   always_comb begin
      tmo_s = 1'b0;
   end
`endif

   // Only the latched target's response is ever looked at
   always_comb begin
      if (tgt_mem_r) begin
         slv_ack_s = bus.mem_ack_i;
         slv_err_s = bus.mem_err_i;
         slv_dat_s = bus.mem_dat_i;
      end else begin
         slv_ack_s = bus.ctrl_ack_i;
         slv_err_s = bus.ctrl_err_i;
         slv_dat_s = bus.ctrl_dat_i;
      end
      // A real ack beats a coincident timeout; a slave error beats its ack
      fail_s = slv_err_s | (tmo_s & ~slv_ack_s);
   end

   // Next-state and next-output computation for the transaction FSM
   always_comb begin
      state_s    = state_r;
      tgt_mem_s  = tgt_mem_r;
      adr_s      = adr_r;
      sel_s      = sel_r;
      wdat_s     = wdat_r;
      mem_cyc_s  = mem_cyc_r;
      ctrl_cyc_s = ctrl_cyc_r;
      mem_we_s   = mem_we_r;
      ctrl_we_s  = ctrl_we_r;
      rdata_s    = rdata_r;
      ack_s      = 1'b0;
      err_s      = 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt_s      = cnt_r;
`endif
      case (state_r)
         IDLE: begin
            if (bus.br_en) begin
               tgt_mem_s  = bus.sel_mem;
               adr_s      = bus.br_addr;
               sel_s      = bus.br_sel;
               wdat_s     = bus.br_wdata;
               mem_cyc_s  = bus.sel_mem;
               ctrl_cyc_s = ~bus.sel_mem;
               mem_we_s   = bus.sel_mem & ~bus.br_rw;
               ctrl_we_s  = ~bus.sel_mem & ~bus.br_rw;
`ifdef BUS_TIMEOUT_EN
               cnt_s      = '0;
`endif
               state_s    = ACTIVE;
            end else begin
               state_s    = IDLE;
            end
         end
         ACTIVE: begin
            if (slv_ack_s | slv_err_s | tmo_s) begin
               mem_cyc_s  = 1'b0;
               ctrl_cyc_s = 1'b0;
               ack_s      = 1'b1;
               err_s      = fail_s;
               // A read leaves the write-enables low, so either one flags a write
               if (!(mem_we_r | ctrl_we_r)) begin
                  rdata_s = fail_s ? ERR_DATA : slv_dat_s;
               end else begin
                  rdata_s = rdata_r;
               end
               mem_we_s   = 1'b0;
               ctrl_we_s  = 1'b0;
               state_s    = RELEASE;
            end else begin
`ifdef BUS_TIMEOUT_EN
               cnt_s      = cnt_r + CNT_W'(1);
`endif
               state_s    = ACTIVE;
            end
         end
         RELEASE: begin
            if (!bus.br_en) begin
               state_s = IDLE;
            end else begin
               state_s = RELEASE;
            end
         end
         default: begin
            state_s    = IDLE;
            mem_cyc_s  = 1'b0;
            ctrl_cyc_s = 1'b0;
            mem_we_s   = 1'b0;
            ctrl_we_s  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge wb_clk_i) begin
      if (!reset_n) begin
         state_r    <= IDLE;
         tgt_mem_r  <= 1'b0;
         adr_r      <= '0;
         sel_r      <= 4'h0;
         wdat_r     <= '0;
         mem_cyc_r  <= 1'b0;
         ctrl_cyc_r <= 1'b0;
         mem_we_r   <= 1'b0;
         ctrl_we_r  <= 1'b0;
         rdata_r    <= '0;
         ack_r      <= 1'b0;
         err_r      <= 1'b0;
`ifdef BUS_TIMEOUT_EN
         cnt_r      <= '0;
`endif
      end else begin
         state_r    <= state_s;
         tgt_mem_r  <= tgt_mem_s;
         adr_r      <= adr_s;
         sel_r      <= sel_s;
         wdat_r     <= wdat_s;
         mem_cyc_r  <= mem_cyc_s;
         ctrl_cyc_r <= ctrl_cyc_s;
         mem_we_r   <= mem_we_s;
         ctrl_we_r  <= ctrl_we_s;
         rdata_r    <= rdata_s;
         ack_r      <= ack_s;
         err_r      <= err_s;
`ifdef BUS_TIMEOUT_EN
         cnt_r      <= cnt_s;
`endif
      end
   end

   assign bus.br_rdata   = rdata_r;
   assign bus.br_ack     = ack_r;
   assign bus.err_o      = err_r;

   assign bus.mem_adr_o  = {{(32-ADDR_W){1'b0}}, adr_r};
   assign bus.mem_sel_o  = sel_r;
   assign bus.mem_we_o   = mem_we_r;
   assign bus.mem_cyc_o  = mem_cyc_r;
   assign bus.mem_stb_o  = mem_cyc_r;
   assign bus.mem_dat_o  = wdat_r;

   assign bus.ctrl_adr_o = adr_r[11:2];
   assign bus.ctrl_sel_o = sel_r;
   assign bus.ctrl_we_o  = ctrl_we_r;
   assign bus.ctrl_cyc_o = ctrl_cyc_r;
   assign bus.ctrl_stb_o = ctrl_cyc_r;
   assign bus.ctrl_dat_o = wdat_r;

endmodule
